flit_buffer: RTL and testbench



---
 rtl/flit_buffer_pkg.sv | 23 ++
 rtl/flit_buffer_vc_fifo.sv | 88 ++++++++
 rtl/flit_buffer.sv | 71 +++++++
 tb/tb_flit_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/flit_buffer_pkg.sv
// Shared constants and helpers for the per-VC flit buffer.
// Entry layout in storage is {tail, head, data}.
package flit_buffer_pkg;

  localparam int ERR_OVERFLOW  = 0;
  localparam int ERR_UNDERFLOW = 1;
  localparam int FLAG_BITS     = 2;

  // Bits needed to encode values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int entry_width(input int data_w);
    return data_w + FLAG_BITS;
  endfunction

endpackage

// File: rtl/flit_buffer_vc_fifo.sv
// Single-VC FIFO: pointers, occupancy count, storage and error pulses.
// Same-cycle push/pop bypass of an empty FIFO exists only when FLIT_BUFFER_BYPASS_EN is defined.
module flit_buffer_vc_fifo
  import flit_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_push_head,
  input  logic              i_push_tail,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_pop_data,
  output logic              o_head_tail,
  output logic              o_empty,
  output logic              o_almost_empty,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam int EW = entry_width(DATA_W);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_do_push;
  logic          w_do_pop;
  logic [EW-1:0] w_head;
  logic          w_unused_head_flag;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

`ifdef FLIT_BUFFER_BYPASS_EN
  assign w_bypass = i_push & i_pop & w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // A pop frees the slot the simultaneous push needs, so full + pop still accepts the push.
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop) & ~w_bypass;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= {i_push_tail, i_push_head, i_push_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      r_count     <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      r_overflow  <= i_push & w_full & ~i_pop;
      r_underflow <= i_pop & w_empty & ~w_bypass;
    end
  end

  assign w_head             = r_mem[r_rd_ptr];
  assign w_unused_head_flag = w_head[DATA_W];

  assign o_pop_data     = w_bypass ? i_push_data : w_head[DATA_W-1:0];
  assign o_head_tail    = ~w_empty & w_head[DATA_W+1];
  assign o_empty        = w_empty;
  assign o_almost_empty = (r_count == CW'(1));
  assign o_full         = w_full;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: rtl/flit_buffer.sv
// Statically partitioned per-VC input flit buffer: num_vcs FIFOs of buffer_size/num_vcs flits.
// Optional same-cycle bypass of an empty VC is enabled by defining FLIT_BUFFER_BYPASS_EN.
module flit_buffer
  import flit_buffer_pkg::*;
#(
  parameter int num_vcs         = 8,
  parameter int buffer_size     = 64,
  parameter int flit_data_width = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_active,
  input  logic                       push_valid,
  input  logic [num_vcs-1:0]         push_sel_ivc,
  input  logic                       push_head,
  input  logic                       push_tail,
  input  logic [flit_data_width-1:0] push_data,
  input  logic                       pop_active,
  input  logic                       pop_valid,
  input  logic [num_vcs-1:0]         pop_sel_ivc,
  output logic [flit_data_width-1:0] pop_data,
  output logic [num_vcs-1:0]         pop_tail_ivc,
  output logic [num_vcs-1:0]         almost_empty_ivc,
  output logic [num_vcs-1:0]         empty_ivc,
  output logic                       full,
  output logic [2*num_vcs-1:0]       errors_ivc
);

  localparam int D = buffer_size / num_vcs;

  logic [num_vcs-1:0]         w_push_oh;
  logic [num_vcs-1:0]         w_pop_oh;
  logic [num_vcs-1:0]         w_full_ivc;
  logic [flit_data_width-1:0] w_vc_data [num_vcs];

  // Isolate the lowest set bit so a malformed select still addresses exactly one VC.
  assign w_push_oh = push_sel_ivc & (~push_sel_ivc + num_vcs'(1));
  assign w_pop_oh  = pop_sel_ivc & (~pop_sel_ivc + num_vcs'(1));

  for (genvar v = 0; v < num_vcs; v++) begin : g_vc
    flit_buffer_vc_fifo #(
      .DEPTH  (D),
      .DATA_W (flit_data_width)
    ) u_fifo (
      .clk            (clk),
      .reset          (reset),
      .i_push         (push_active & push_valid & w_push_oh[v]),
      .i_push_head    (push_head),
      .i_push_tail    (push_tail),
      .i_push_data    (push_data),
      .i_pop          (pop_active & pop_valid & w_pop_oh[v]),
      .o_pop_data     (w_vc_data[v]),
      .o_head_tail    (pop_tail_ivc[v]),
      .o_empty        (empty_ivc[v]),
      .o_almost_empty (almost_empty_ivc[v]),
      .o_full         (w_full_ivc[v]),
      .o_overflow     (errors_ivc[2*v+ERR_OVERFLOW]),
      .o_underflow    (errors_ivc[2*v+ERR_UNDERFLOW])
    );
  end

  always_comb begin
    pop_data = '0;
    for (int v = 0; v < num_vcs; v++) begin
      if (w_pop_oh[v]) pop_data = w_vc_data[v];
    end
  end

  assign full = |w_full_ivc;

endmodule

// File: tb/tb_flit_buffer.sv
// Directed bench for flit_buffer (8 VCs, depth 8, 64-bit flits).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_flit_buffer;

  logic        clk;
  logic        reset;
  logic        push_active;
  logic        push_valid;
  logic [7:0]  push_sel_ivc;
  logic        push_head;
  logic        push_tail;
  logic [63:0] push_data;
  logic        pop_active;
  logic        pop_valid;
  logic [7:0]  pop_sel_ivc;
  logic [63:0] pop_data;
  logic [7:0]  pop_tail_ivc;
  logic [7:0]  almost_empty_ivc;
  logic [7:0]  empty_ivc;
  logic        full;
  logic [15:0] errors_ivc;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;

  flit_buffer #(
    .num_vcs         (8),
    .buffer_size     (64),
    .flit_data_width (64)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .push_active      (push_active),
    .push_valid       (push_valid),
    .push_sel_ivc     (push_sel_ivc),
    .push_head        (push_head),
    .push_tail        (push_tail),
    .push_data        (push_data),
    .pop_active       (pop_active),
    .pop_valid        (pop_valid),
    .pop_sel_ivc      (pop_sel_ivc),
    .pop_data         (pop_data),
    .pop_tail_ivc     (pop_tail_ivc),
    .almost_empty_ivc (almost_empty_ivc),
    .empty_ivc        (empty_ivc),
    .full             (full),
    .errors_ivc       (errors_ivc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus: applied at the falling edge, outputs settle by #1.
  task automatic drive(input logic pa, input logic pv, input logic [7:0] psel,
                       input logic [63:0] pd, input logic pt,
                       input logic qa, input logic qv, input logic [7:0] qsel);
    @(negedge clk);
    push_active  = pa;
    push_valid   = pv;
    push_sel_ivc = psel;
    push_head    = 1'b0;
    push_data    = pd;
    push_tail    = pt;
    pop_active   = qa;
    pop_valid    = qv;
    pop_sel_ivc  = qsel;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic push(input logic [7:0] sel, input logic [63:0] d, input logic t);
    drive(1'b1, 1'b1, sel, d, t, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic pop(input logic [7:0] sel);
    drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b1, sel);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle();
    n_cmp++; if (empty_ivc !== 8'hFF) begin n_fail++; $display("FAIL reset_empty: got %h want ff", empty_ivc); end
    n_cmp++; if (almost_empty_ivc !== 8'h00) begin n_fail++; $display("FAIL reset_almost: got %h want 00", almost_empty_ivc); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (errors_ivc !== 16'h0000) begin n_fail++; $display("FAIL reset_errors: got %h want 0000", errors_ivc); end
    n_cmp++; if (pop_tail_ivc !== 8'h00) begin n_fail++; $display("FAIL reset_tail: got %h want 00", pop_tail_ivc); end
  endtask

  task automatic test_fifo_order();
    push(8'h04, 64'd1, 1'b0);
    push(8'h04, 64'd2, 1'b0);
    n_cmp++; if (almost_empty_ivc !== 8'h04) begin n_fail++; $display("FAIL order_almost1: got %h want 04", almost_empty_ivc); end
    push(8'h04, 64'd3, 1'b1);
    idle();
    n_cmp++; if (empty_ivc !== 8'hFB) begin n_fail++; $display("FAIL order_empty3: got %h want fb", empty_ivc); end
    pop(8'h04);
    n_cmp++; if (pop_data !== 64'd1) begin n_fail++; $display("FAIL order_pop1: got %0d want 1", pop_data); end
    n_cmp++; if (pop_tail_ivc !== 8'h00) begin n_fail++; $display("FAIL order_tail1: got %h want 00", pop_tail_ivc); end
    pop(8'h04);
    n_cmp++; if (pop_data !== 64'd2) begin n_fail++; $display("FAIL order_pop2: got %0d want 2", pop_data); end
    n_cmp++; if (pop_tail_ivc !== 8'h00) begin n_fail++; $display("FAIL order_tail2: got %h want 00", pop_tail_ivc); end
    pop(8'h04);
    n_cmp++; if (pop_data !== 64'd3) begin n_fail++; $display("FAIL order_pop3: got %0d want 3", pop_data); end
    n_cmp++; if (pop_tail_ivc !== 8'h04) begin n_fail++; $display("FAIL order_tail3: got %h want 04", pop_tail_ivc); end
    n_cmp++; if (almost_empty_ivc !== 8'h04) begin n_fail++; $display("FAIL order_almost3: got %h want 04", almost_empty_ivc); end
    idle();
    n_cmp++; if (empty_ivc !== 8'hFF) begin n_fail++; $display("FAIL order_drained: got %h want ff", empty_ivc); end
    n_cmp++; if (pop_tail_ivc !== 8'h00) begin n_fail++; $display("FAIL order_tail_clr: got %h want 00", pop_tail_ivc); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      push(8'h01, 64'h10 + 64'(i), 1'b0);
      exp_q.push_back(64'h10 + 64'(i));
    end
    idle();
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", full); end
    n_cmp++; if (errors_ivc !== 16'h0000) begin n_fail++; $display("FAIL ovf_noerr: got %h want 0000", errors_ivc); end
    push(8'h01, 64'h99, 1'b0);
    idle();
    n_cmp++; if (errors_ivc !== 16'h0001) begin n_fail++; $display("FAIL ovf_flag: got %h want 0001", errors_ivc); end
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full2: got %b want 1", full); end
    drive(1'b1, 1'b1, 8'h01, 64'h20, 1'b0, 1'b1, 1'b1, 8'h01);
    exp_v = exp_q.pop_front();
    exp_q.push_back(64'h20);
    n_cmp++; if (pop_data !== exp_v) begin n_fail++; $display("FAIL ovf_pp_data: got %h want %h", pop_data, exp_v); end
    n_cmp++; if (errors_ivc !== 16'h0000) begin n_fail++; $display("FAIL ovf_pulse: got %h want 0000", errors_ivc); end
    idle();
    n_cmp++; if (errors_ivc !== 16'h0000) begin n_fail++; $display("FAIL ovf_pp_err: got %h want 0000", errors_ivc); end
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_pp_full: got %b want 1", full); end
    for (int i = 0; i < 8; i++) begin
      pop(8'h01);
      exp_v = exp_q.pop_front();
      n_cmp++; if (pop_data !== exp_v) begin n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", i, pop_data, exp_v); end
    end
    idle();
    n_cmp++; if (empty_ivc !== 8'hFF || full !== 1'b0) begin n_fail++; $display("FAIL ovf_end: got empty %h full %b want ff 0", empty_ivc, full); end
  endtask

  task automatic test_underflow();
    pop(8'h20);
    idle();
    n_cmp++; if (errors_ivc !== 16'h0800) begin n_fail++; $display("FAIL udf_flag: got %h want 0800", errors_ivc); end
    push(8'h20, 64'h55, 1'b0);
    n_cmp++; if (errors_ivc !== 16'h0000) begin n_fail++; $display("FAIL udf_pulse: got %h want 0000", errors_ivc); end
    pop(8'h20);
    n_cmp++; if (pop_data !== 64'h55) begin n_fail++; $display("FAIL udf_ptr: got %h want 55", pop_data); end
    idle();
    n_cmp++; if (empty_ivc !== 8'hFF) begin n_fail++; $display("FAIL udf_empty: got %h want ff", empty_ivc); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b1, 8'h08, 64'hAB, 1'b0, 1'b1, 1'b1, 8'h08);
`ifdef FLIT_BUFFER_BYPASS_EN
    n_cmp++; if (pop_data !== 64'hAB) begin n_fail++; $display("FAIL byp_data: got %h want ab", pop_data); end
    idle();
    n_cmp++; if (errors_ivc !== 16'h0000) begin n_fail++; $display("FAIL byp_err: got %h want 0000", errors_ivc); end
    n_cmp++; if (empty_ivc !== 8'hFF) begin n_fail++; $display("FAIL byp_empty: got %h want ff", empty_ivc); end
`else
    idle();
    n_cmp++; if (errors_ivc !== 16'h0080) begin n_fail++; $display("FAIL byp_udf: got %h want 0080", errors_ivc); end
    n_cmp++; if (almost_empty_ivc !== 8'h08) begin n_fail++; $display("FAIL byp_count1: got %h want 08", almost_empty_ivc); end
    pop(8'h08);
    n_cmp++; if (pop_data !== 64'hAB) begin n_fail++; $display("FAIL byp_written: got %h want ab", pop_data); end
    idle();
    n_cmp++; if (empty_ivc !== 8'hFF) begin n_fail++; $display("FAIL byp_empty: got %h want ff", empty_ivc); end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) push(8'h02, 64'h40 + 64'(i), 1'b0);
    idle();
    n_cmp++; if (empty_ivc !== 8'hFD) begin n_fail++; $display("FAIL rst_filled: got %h want fd", empty_ivc); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (empty_ivc !== 8'hFF) begin n_fail++; $display("FAIL rst_async: got %h want ff", empty_ivc); end
    @(negedge clk);
    reset = 1'b0;
    pop(8'h02);
    idle();
    n_cmp++; if (errors_ivc !== 16'h0008) begin n_fail++; $display("FAIL rst_udf: got %h want 0008", errors_ivc); end
  endtask

  task automatic test_select_and_gating();
    push(8'h30, 64'h77, 1'b0);
    drive(1'b1, 1'b1, 8'h40, 64'h66, 1'b0, 1'b1, 1'b1, 8'h90);
    n_cmp++; if (pop_data !== 64'h77) begin n_fail++; $display("FAIL sel_lowest: got %h want 77", pop_data); end
    drive(1'b0, 1'b1, 8'h01, 64'h11, 1'b0, 1'b0, 1'b1, 8'h40);
    n_cmp++; if (empty_ivc !== 8'hBF) begin n_fail++; $display("FAIL sel_indep: got %h want bf", empty_ivc); end
    pop(8'h40);
    n_cmp++; if (pop_data !== 64'h66) begin n_fail++; $display("FAIL sel_vc6: got %h want 66", pop_data); end
    n_cmp++; if (empty_ivc !== 8'hBF || errors_ivc !== 16'h0000) begin n_fail++; $display("FAIL gate_inactive: got empty %h err %h want bf 0000", empty_ivc, errors_ivc); end
    idle();
    n_cmp++; if (empty_ivc !== 8'hFF) begin n_fail++; $display("FAIL sel_end: got %h want ff", empty_ivc); end
  endtask

  initial begin
    reset        = 1'b1;
    push_active  = 1'b0;
    push_valid   = 1'b0;
    push_sel_ivc = '0;
    push_head    = 1'b0;
    push_tail    = 1'b0;
    push_data    = '0;
    pop_active   = 1'b0;
    pop_valid    = 1'b0;
    pop_sel_ivc  = '0;
    test_reset();
    test_fifo_order();
    test_overflow();
    test_underflow();
    test_bypass();
    test_reset_mid();
    test_select_and_gating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
